cache_ctrl_assoc: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate cache controller with internal tag/valid/dirty/data storage.
- Sits between the processor memory port and the RAM model.
- Adds three things the prior direct-mapped controller lacked: req/ack handshake, round-robin replacement, and full flush (clear = write back dirty, then invalidate).
- Supports indirect access: pointer fetched through the cache, then the real access. Keeps hit/miss counters.

---
 rtl/cache_ctrl_assoc.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_cache_ctrl_assoc.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_assoc.sv
// cache_ctrl_assoc
// N-way set-associative, write-back, write-allocate cache controller with
// one data word per line. It uses a req/ack handshake, round-robin
// replacement, full flush (write back dirty lines, then invalidate),
// indirect access (pointer fetched through the cache) and saturating
// hit/miss counters.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   req, op, indirect   request strobe (sampled in IDLE), op 00 clear,
//                       01 nop, 10 read, 11 write; indirect = addr holds a pointer
//   addr, wdata         request address and write data
//   busy, ack, rdata    busy from acceptance+1 through ack; 1-cycle ack;
//                       read result held until the next ack
//   hit_cnt, miss_cnt   saturating lookup counters
//   mem_req, mem_we     RAM request, 1 = write-back / 0 = fill
//   mem_addr, mem_wdata RAM word address and write-back data
//   mem_rdata, mem_ready fill data and single-cycle RAM completion
module cache_ctrl_assoc #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int SET_BITS = 2,
   parameter int WAYS     = 2,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [1:0]        op,
   input  logic              indirect,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);
   localparam int SETS  = 1 << SET_BITS;
   localparam int TAG_W = ADDR_W - SET_BITS;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {
      IDLE, LOOKUP, WRITEBACK, FILL, IND_ADDR, FLUSH_SCAN, FLUSH_WB, RESPOND
   } state_t;

   state_t state, next_state;

   logic [1:0]        op_r;
   logic              ind_r;      // pointer phase pending: lookup is a read into ptr_r
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r, ptr_r;
   logic [WAY_W-1:0]  vic;
   logic [SET_BITS-1:0] fs;
   logic [WAY_W-1:0]  fw;

   logic              valid    [SETS][WAYS];
   logic              dirty    [SETS][WAYS];
   logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
   logic [DATA_W-1:0] data_mem [SETS][WAYS];
   logic [WAY_W-1:0]  rr       [SETS];

   logic [SET_BITS-1:0] set_idx;
   logic [TAG_W-1:0]    tag_in;
   logic                hit, inv_found, rd_op, vdirty, done, last;
   logic [WAY_W-1:0]    hit_way, inv_way, victim, rr_next;
   logic                wr_en, install, wr_dirty;
   logic [WAY_W-1:0]    wr_way;
   logic [DATA_W-1:0]   wr_data;
   logic [ADDR_W-1:0]   ptr_addr;

   assign set_idx = addr_r[SET_BITS-1:0];
   assign tag_in  = addr_r[ADDR_W-1:SET_BITS];
   assign rd_op   = ind_r | (op_r == 2'b10);
   assign done    = mem_req & mem_ready;
   assign last    = (fs == SET_BITS'(SETS-1)) && (fw == WAY_W'(WAYS-1));
   assign rr_next = (rr[set_idx] == WAY_W'(WAYS-1)) ? '0 : rr[set_idx] + 1'b1;

   // Pointer word resized to an address (truncate or zero-extend).
   generate
      if (DATA_W >= ADDR_W) begin : g_trunc
         assign ptr_addr = ptr_r[ADDR_W-1:0];
      end else begin : g_zext
         assign ptr_addr = {{(ADDR_W-DATA_W){1'b0}}, ptr_r};
      end
   endgenerate

   // Tag match and victim selection: lowest invalid way, else round-robin.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid[set_idx][WAY_W'(w)] && (tag_mem[set_idx][WAY_W'(w)] == tag_in) && !hit) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid[set_idx][WAY_W'(w)] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      victim = inv_found ? inv_way : rr[set_idx];
      vdirty = dirty[set_idx][victim];
   end

   // Line array writes: write hit, write-miss install, fill install.
   always_comb begin
      wr_en    = 1'b0;
      install  = 1'b0;
      wr_way   = vic;
      wr_data  = wdata_r;
      wr_dirty = 1'b1;
      case (state)
         LOOKUP: if (!rd_op) begin
            if (hit) begin
               wr_en  = 1'b1;
               wr_way = hit_way;
            end else if (!vdirty) begin
               wr_en   = 1'b1;
               install = 1'b1;
               wr_way  = victim;
            end
         end
         WRITEBACK: if (done && !rd_op) begin
            wr_en   = 1'b1;
            install = 1'b1;
         end
         FILL: if (done) begin
            wr_en    = 1'b1;
            install  = 1'b1;
            wr_data  = mem_rdata;
            wr_dirty = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy       = (state != IDLE);
      ack        = (state == RESPOND);
      case (state)
         IDLE: if (req) begin
            case (op)
               2'b00:   next_state = FLUSH_SCAN;
               2'b01:   next_state = RESPOND;
               default: next_state = LOOKUP;
            endcase
         end
         LOOKUP: begin
            if (hit)         next_state = ind_r ? IND_ADDR : RESPOND;
            else if (vdirty) next_state = WRITEBACK;
            else if (rd_op)  next_state = FILL;
            else             next_state = RESPOND;
         end
         WRITEBACK:  if (done) next_state = rd_op ? FILL : RESPOND;
         FILL:       if (done) next_state = ind_r ? IND_ADDR : RESPOND;
         IND_ADDR:   next_state = LOOKUP;
         FLUSH_SCAN: begin
            if (dirty[fs][fw]) next_state = FLUSH_WB;
            else if (last)     next_state = RESPOND;
         end
         FLUSH_WB:   if (done) next_state = FLUSH_SCAN;
         RESPOND:    next_state = IDLE;
         default:    next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
               valid[SET_BITS'(s)][WAY_W'(w)] <= 1'b0;
               dirty[SET_BITS'(s)][WAY_W'(w)] <= 1'b0;
            end
            rr[SET_BITS'(s)] <= '0;
         end
         op_r      <= '0;
         ind_r     <= 1'b0;
         addr_r    <= '0;
         wdata_r   <= '0;
         ptr_r     <= '0;
         vic       <= '0;
         fs        <= '0;
         fw        <= '0;
         rdata     <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: if (req) begin
               op_r    <= op;
               ind_r   <= indirect & op[1];
               addr_r  <= addr;
               wdata_r <= wdata;
               fs      <= '0;
               fw      <= '0;
            end
            LOOKUP: begin
               vic <= victim;
               if (hit) begin
                  if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                  if (rd_op) begin
                     if (ind_r) ptr_r <= data_mem[set_idx][hit_way];
                     else       rdata <= data_mem[set_idx][hit_way];
                  end
               end else if (miss_cnt != '1) begin
                  miss_cnt <= miss_cnt + 1'b1;
               end
            end
            WRITEBACK: if (done) dirty[set_idx][vic] <= 1'b0;
            FILL: if (done) begin
               if (ind_r) ptr_r <= mem_rdata;
               else       rdata <= mem_rdata;
            end
            IND_ADDR: begin
               addr_r <= ptr_addr;
               ind_r  <= 1'b0;
            end
            FLUSH_SCAN: if (!dirty[fs][fw]) begin
               valid[fs][fw] <= 1'b0;
               if (last) begin
                  for (int unsigned s = 0; s < SETS; s++) rr[SET_BITS'(s)] <= '0;
               end else if (fw == WAY_W'(WAYS-1)) begin
                  fw <= '0;
                  fs <= fs + 1'b1;
               end else begin
                  fw <= fw + 1'b1;
               end
            end
            FLUSH_WB: if (done) dirty[fs][fw] <= 1'b0;
            default: ;
         endcase

         // Placed after the case so a write-miss install that follows a
         // write-back re-marks the same line dirty.
         if (wr_en) begin
            valid[set_idx][wr_way] <= 1'b1;
            dirty[set_idx][wr_way] <= wr_dirty;
            if (install) rr[set_idx] <= rr_next;
         end

         // Each RAM transfer raises mem_req from a low cycle, holds it with
         // stable address/data until mem_ready, and drops it the next cycle.
         if (state == WRITEBACK || state == FILL || state == FLUSH_WB) begin
            if (!mem_req) begin
               mem_req <= 1'b1;
               mem_we  <= (state != FILL);
               if (state == FLUSH_WB) begin
                  mem_addr  <= {tag_mem[fs][fw], fs};
                  mem_wdata <= data_mem[fs][fw];
               end else if (state == WRITEBACK) begin
                  mem_addr  <= {tag_mem[set_idx][vic], set_idx};
                  mem_wdata <= data_mem[set_idx][vic];
               end else begin
                  mem_addr <= addr_r;
               end
            end else if (mem_ready) begin
               mem_req <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[set_idx][wr_way]  <= tag_in;
         data_mem[set_idx][wr_way] <= wr_data;
      end
   end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Testbench for cache_ctrl_assoc: directed vector table, hand-written
// corner sequences (reset mid-fill, req while busy, counter saturation),
// and randomized traffic against a flat-memory reference model.
module tb_cache_ctrl_assoc;
   localparam int DATA_W = 8, ADDR_W = 8, SET_BITS = 2, WAYS = 2, CNT_W = 4;
   localparam int SETS = 1 << SET_BITS;
   localparam int SAT  = (1 << CNT_W) - 1;
   localparam logic [1:0] OP_CLR = 2'b00, OP_NOP = 2'b01, OP_RD = 2'b10, OP_WR = 2'b11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, req, indirect, busy, ack, mem_req, mem_we, mem_ready;
   logic [1:0]        op;
   logic [ADDR_W-1:0] addr, mem_addr;
   logic [DATA_W-1:0] wdata, rdata, mem_wdata, mem_rdata;
   logic [CNT_W-1:0]  hit_cnt, miss_cnt;

   cache_ctrl_assoc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SET_BITS(SET_BITS),
                      .WAYS(WAYS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .indirect(indirect),
      .addr(addr), .wdata(wdata), .busy(busy), .ack(ack), .rdata(rdata),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0, n_total = 0;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endtask

   // RAM model: answers mem_req after ram_wait low-ready cycles.
   typedef struct { bit we; logic [7:0] a; logic [7:0] d; } mtx_t;
   logic [7:0] ram [256];
   mtx_t log_q[$];
   int ram_wait = 3, wcnt = 0, ready_cyc = 0, ack_cyc = 0;
   always @(negedge clk) begin
      mtx_t t;
      if (mem_ready) mem_ready = 1'b0;
      else if (mem_req) begin
         if (wcnt >= ram_wait) begin
            mem_ready = 1'b1;
            wcnt = 0;
            ready_cyc = cyc;
            if (mem_we) ram[mem_addr] = mem_wdata;
            else mem_rdata = ram[mem_addr];
            t.we = mem_we; t.a = mem_addr; t.d = mem_we ? mem_wdata : ram[mem_addr];
            log_q.push_back(t);
         end else wcnt++;
      end else wcnt = 0;
   end

   task automatic txn(input logic [1:0] o, input bit ind, input logic [7:0] a,
                      input logic [7:0] wd, output logic [7:0] rd, output int lat,
                      output bit gap);
      log_q.delete();
      op = o; indirect = ind; addr = a; wdata = wd; req = 1'b1;
      @(negedge clk);
      req = 1'b0; lat = 1; gap = 0;
      while (!ack && lat < 3000) begin
         if (!busy) gap = 1;
         @(negedge clk);
         lat++;
      end
      if (!ack) lat = -1;
      ack_cyc = cyc;
      rd = rdata;
      @(negedge clk);
   endtask

   task automatic do_reset();
      req = 1'b0; rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Reference: the cache must look like a flat memory (golden); tag state
   // only predicts hit/miss from the replacement rules.
   logic [7:0] golden [256];
   bit  m_val [SETS][WAYS];
   int  m_tag [SETS][WAYS];
   int  m_rr  [SETS];
   int  m_hits, m_miss;

   task automatic m_reset();
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) m_val[s][w] = 0;
         m_rr[s] = 0;
      end
      m_hits = 0; m_miss = 0;
   endtask

   task automatic m_access(input logic [7:0] a, input bit wr, input logic [7:0] wd,
                           output logic [7:0] rd);
      int s = int'(a) % SETS;
      int t = int'(a) / SETS;
      int vic = -1;
      bit h = 0;
      for (int w = 0; w < WAYS; w++) if (m_val[s][w] && m_tag[s][w] == t) h = 1;
      if (h) m_hits = (m_hits < SAT) ? m_hits + 1 : SAT;
      else begin
         m_miss = (m_miss < SAT) ? m_miss + 1 : SAT;
         for (int w = 0; w < WAYS; w++) if (!m_val[s][w] && vic < 0) vic = w;
         if (vic < 0) vic = m_rr[s];
         m_val[s][vic] = 1; m_tag[s][vic] = t;
         m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      rd = golden[a];
      if (wr) golden[a] = wd;
   endtask

   typedef struct {
      logic [1:0] op; bit ind; logic [7:0] a; logic [7:0] wd;
      bit chk_rd; logic [7:0] rd; int lat_mode; int lat;   // 1 exact, 2 ack = ready+1
      int nrd; int nwr; logic [7:0] wa; logic [7:0] wdat; int hit; int miss;
   } vec_t;
   localparam int NV = 17;
   vec_t v [NV];

   initial begin
      logic [7:0] got, erd, p;
      int lat, nrd, nwr, acks, mism;
      bit gap, seen, fw_found;
      logic [7:0] fwa, fwd;

      rst_n = 1'b0; req = 1'b0; op = OP_NOP; indirect = 1'b0; addr = '0; wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
      ram[8'h05] = 8'h3C; ram[8'h02] = 8'h40; ram[8'h40] = 8'h77;

      v[0]  = '{OP_RD,  0, 8'h05, 8'h00, 1, 8'h3C, 2, 0, 1, 0, 8'h00, 8'h00, 0, 1};
      v[1]  = '{OP_RD,  0, 8'h05, 8'h00, 1, 8'h3C, 1, 2, 0, 0, 8'h00, 8'h00, 1, 1};
      v[2]  = '{OP_WR,  0, 8'h01, 8'hAA, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 2};
      v[3]  = '{OP_RD,  0, 8'h01, 8'h00, 1, 8'hAA, 1, 2, 0, 0, 8'h00, 8'h00, 2, 2};
      v[4]  = '{OP_WR,  0, 8'h05, 8'h11, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 3, 2};
      v[5]  = '{OP_WR,  0, 8'h09, 8'h99, 0, 8'h00, 0, 0, 0, 1, 8'h05, 8'h11, 3, 3};
      v[6]  = '{OP_RD,  0, 8'h0D, 8'h00, 1, 8'h57, 0, 0, 1, 1, 8'h01, 8'hAA, 3, 4};
      v[7]  = '{OP_RD,  0, 8'h01, 8'h00, 1, 8'hAA, 0, 0, 1, 1, 8'h09, 8'h99, 3, 5};
      v[8]  = '{OP_NOP, 0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00, 3, 5};
      v[9]  = '{OP_RD,  1, 8'h02, 8'h00, 1, 8'h77, 0, 0, 2, 0, 8'h00, 8'h00, 3, 7};
      v[10] = '{OP_RD,  0, 8'h40, 8'h00, 1, 8'h77, 1, 2, 0, 0, 8'h00, 8'h00, 4, 7};
      v[11] = '{OP_WR,  0, 8'h40, 8'h21, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 5, 7};
      v[12] = '{OP_WR,  0, 8'h02, 8'h22, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 6, 7};
      v[13] = '{OP_CLR, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 2, 8'h40, 8'h21, 6, 7};
      v[14] = '{OP_CLR, 0, 8'h00, 8'h00, 0, 8'h00, 1, SETS*WAYS+1, 0, 0, 8'h00, 8'h00, 6, 7};
      v[15] = '{OP_RD,  0, 8'h40, 8'h00, 1, 8'h21, 2, 0, 1, 0, 8'h00, 8'h00, 6, 8};
      v[16] = '{OP_RD,  0, 8'h02, 8'h00, 1, 8'h22, 2, 0, 1, 0, 8'h00, 8'h00, 6, 9};

      repeat (3) @(negedge clk);
      check("reset busy", busy, 0);     check("reset ack", ack, 0);
      check("reset mem_req", mem_req, 0); check("reset rdata", rdata, 0);
      check("reset hit_cnt", hit_cnt, 0); check("reset miss_cnt", miss_cnt, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         txn(v[i].op, v[i].ind, v[i].a, v[i].wd, got, lat, gap);
         nrd = 0; nwr = 0; fw_found = 0; fwa = '0; fwd = '0;
         foreach (log_q[k]) begin
            if (log_q[k].we) begin
               if (!fw_found) begin fwa = log_q[k].a; fwd = log_q[k].d; fw_found = 1; end
               nwr++;
            end else nrd++;
         end
         check($sformatf("v%0d acked", i), lat > 0, 1);
         if (v[i].chk_rd) check($sformatf("v%0d rdata", i), got, v[i].rd);
         if (v[i].lat_mode == 1) check($sformatf("v%0d latency", i), lat, v[i].lat);
         if (v[i].lat_mode == 2) check($sformatf("v%0d ack after ready", i), ack_cyc, ready_cyc + 1);
         check($sformatf("v%0d ram reads", i), nrd, v[i].nrd);
         check($sformatf("v%0d ram writes", i), nwr, v[i].nwr);
         if (v[i].nwr > 0) begin
            check($sformatf("v%0d wb addr", i), fwa, v[i].wa);
            check($sformatf("v%0d wb data", i), fwd, v[i].wdat);
         end
         check($sformatf("v%0d hit_cnt", i), hit_cnt, v[i].hit);
         check($sformatf("v%0d miss_cnt", i), miss_cnt, v[i].miss);
         check($sformatf("v%0d busy gap", i), gap, 0);
      end

      // Reset while a fill is stalled on the RAM.
      txn(OP_RD, 0, 8'h40, 8'h00, got, lat, gap);
      check("pre-reset hit", hit_cnt, 7);
      ram_wait = 1000;
      op = OP_RD; indirect = 0; addr = 8'h07; req = 1'b1;
      @(negedge clk);
      req = 1'b0; seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (mem_req) seen = 1; else @(negedge clk);
      end
      check("fill mem_req seen", seen, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst mem_req", mem_req, 0); check("rst busy", busy, 0);
      check("rst ack", ack, 0);         check("rst miss_cnt", miss_cnt, 0);
      check("rst rdata", rdata, 0);
      rst_n = 1'b1; ram_wait = 3;
      @(negedge clk);
      txn(OP_RD, 0, 8'h40, 8'h00, got, lat, gap);
      check("post-rst miss", miss_cnt, 1);
      check("post-rst fill", log_q.size(), 1);
      check("post-rst rdata", got, 8'h21);

      // req held while busy must be ignored.
      op = OP_RD; indirect = 0; addr = 8'h22; req = 1'b1;
      @(negedge clk);
      addr = 8'h23;
      @(negedge clk); @(negedge clk);
      req = 1'b0; acks = 0; got = '0;
      for (int k = 0; k < 30; k++) begin
         if (ack) begin acks++; got = rdata; end
         @(negedge clk);
      end
      check("busy req acks", acks, 1);
      check("busy req rdata", got, 8'h22 ^ 8'h5A);
      check("busy req miss_cnt", miss_cnt, 2);

      // Hit counter saturates instead of wrapping.
      for (int k = 0; k < 14; k++) txn(OP_RD, 0, 8'h22, 8'h00, got, lat, gap);
      check("hit_cnt 14", hit_cnt, 14);
      for (int k = 0; k < 6; k++) txn(OP_RD, 0, 8'h22, 8'h00, got, lat, gap);
      check("hit_cnt sat", hit_cnt, SAT);
      check("miss_cnt after hits", miss_cnt, 2);

      // Randomized traffic against the reference model.
      txn(OP_CLR, 0, 8'h00, 8'h00, got, lat, gap);
      do_reset();
      for (int i = 0; i < 256; i++) golden[i] = ram[i];
      m_reset();
      for (int b = 0; b < 30; b++) begin
         ram_wait = $urandom_range(0, 3);
         for (int k = 0; k < 5; k++) begin
            int kind = $urandom_range(0, 9);
            logic [7:0] a = 8'($urandom_range(0, 15));
            logic [7:0] wd = 8'($urandom_range(0, 15));
            bit is_rd = 0;
            erd = '0;
            case (kind)
               0, 1, 2, 3: begin m_access(a, 0, 8'h00, erd); is_rd = 1;
                              txn(OP_RD, 0, a, wd, got, lat, gap); end
               4, 5, 6:    begin m_access(a, 1, wd, erd);
                              txn(OP_WR, 0, a, wd, got, lat, gap); end
               7:          begin m_access(a, 0, 8'h00, p); m_access(p, 0, 8'h00, erd); is_rd = 1;
                              txn(OP_RD, 1, a, wd, got, lat, gap); end
               8:          begin m_access(a, 0, 8'h00, p); m_access(p, 1, wd, erd);
                              txn(OP_WR, 1, a, wd, got, lat, gap); end
               default:    txn(OP_NOP, 0, a, wd, got, lat, gap);
            endcase
            check("rnd acked", lat > 0, 1);
            if (is_rd) check($sformatf("rnd b%0d k%0d rdata", b, k), got, erd);
            check($sformatf("rnd b%0d k%0d hit_cnt", b, k), hit_cnt, m_hits);
            check($sformatf("rnd b%0d k%0d miss_cnt", b, k), miss_cnt, m_miss);
         end
         txn(OP_CLR, 0, 8'h00, 8'h00, got, lat, gap);
         mism = 0;
         for (int i = 0; i < 256; i++) if (ram[i] !== golden[i]) mism++;
         check($sformatf("rnd b%0d ram after clear", b), mism, 0);
         do_reset();
         m_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end
endmodule
